// File: rtl/led_demux_meter.sv
// LED demultiplexing on-time meter.
// Samples a multiplexed LED drive (11 cathodes, 3 anodes), accumulates per-channel on-cycles
// over a 2^WIN_LOG2-cycle window and publishes the totals to a readable result bank.
// Optional macro LED_DEMUX_COLOR_MAP_EN: reads select a colour (R/G/B) instead of an anode.
module led_demux_meter #(
  parameter int unsigned WIN_LOG2 = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] ledc,
  input  logic [2:0]  leda,
  input  logic        rd_req,
  input  logic [5:0]  rd_addr,
  output logic        rd_ack,
  output logic [15:0] rd_data,
  output logic        win_done,
  output logic        err_anode,
  input  logic        err_clr
);

  localparam int unsigned NumLed = 11;
  localparam int unsigned NumAnode = 3;
  localparam int unsigned NumCh = NumLed * NumAnode;

  typedef logic [WIN_LOG2-1:0] cnt_t;
  localparam cnt_t CntMax = '1;

  logic [10:0] ledc_q;
  logic [2:0]  leda_q;
  // Set once the input registers hold a real post-reset sample
  logic        samp_q;

  cnt_t acc_q  [NumCh];
  cnt_t acc_d  [NumCh];
  cnt_t bank_q [NumCh];
  cnt_t win_q;

  logic onehot;
  logic valid;
  logic invalid;
  logic wrap;

  logic [5:0]  rd_idx;
  logic [15:0] rd_val;

  assign onehot  = (leda_q == 3'b001) || (leda_q == 3'b010) || (leda_q == 3'b100);
  assign valid   = samp_q && onehot;
  assign invalid = samp_q && !onehot;
  assign wrap    = samp_q && (win_q == CntMax);

  // Per-channel saturating increment; channel index is led*3 + anode
  for (genvar gi = 0; gi < NumLed; gi++) begin : g_led
    for (genvar gk = 0; gk < NumAnode; gk++) begin : g_anode
      localparam int Idx = gi * NumAnode + gk;
      assign acc_d[Idx] = (valid && leda_q[gk] && ledc[0] == ledc[0] && ledc_q[gi] &&
                           (acc_q[Idx] != CntMax)) ? acc_q[Idx] + cnt_t'(1) : acc_q[Idx];
    end
  end

`ifdef LED_DEMUX_COLOR_MAP_EN
  // Anode that carries each colour, indexed by LED number
  localparam logic [1:0] RMap [NumLed] = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd1,
                                           2'd1, 2'd0, 2'd0};
  localparam logic [1:0] GMap [NumLed] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0,
                                           2'd0, 2'd1, 2'd1};
  localparam logic [1:0] BMap [NumLed] = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2,
                                           2'd2, 2'd2, 2'd2};
  logic [5:0] rd_led;
  logic [1:0] rd_sel;
  logic [1:0] rd_anode;

  // Translate (led, colour) read address into the (led, anode) channel index
  always_comb begin
    rd_led   = rd_addr / 6'd3;
    rd_sel   = 2'(rd_addr % 6'd3);
    rd_anode = 2'd0;
    if (rd_led < 6'(NumLed)) begin
      unique case (rd_sel)
        2'd0:    rd_anode = RMap[rd_led[3:0]];
        2'd1:    rd_anode = GMap[rd_led[3:0]];
        2'd2:    rd_anode = BMap[rd_led[3:0]];
        default: rd_anode = 2'd0;
      endcase
    end
    rd_idx = rd_led * 6'd3 + {4'd0, rd_anode};
  end
`else
  assign rd_idx = rd_addr;
`endif

  // Out-of-range channels read as zero
  always_comb begin
    rd_val = 16'd0;
    if (rd_addr < 6'(NumCh)) begin
      rd_val = 16'(bank_q[rd_idx]);
    end
  end

  // Input capture, accumulation, window roll-over, error flag and read port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ledc_q    <= '0;
      leda_q    <= '0;
      samp_q    <= 1'b0;
      acc_q     <= '{default: '0};
      bank_q    <= '{default: '0};
      win_q     <= '0;
      win_done  <= 1'b0;
      err_anode <= 1'b0;
      rd_ack    <= 1'b0;
      rd_data   <= '0;
    end else begin
      ledc_q   <= ledc;
      leda_q   <= leda;
      samp_q   <= 1'b1;
      win_done <= wrap;
      if (samp_q) begin
        win_q <= win_q + cnt_t'(1);
      end
      if (wrap) begin
        bank_q <= acc_d;
        acc_q  <= '{default: '0};
      end else begin
        acc_q <= acc_d;
      end
      // A new error wins over a simultaneous clear
      if (invalid) begin
        err_anode <= 1'b1;
      end else if (err_clr) begin
        err_anode <= 1'b0;
      end
      rd_ack  <= rd_req;
      rd_data <= rd_req ? rd_val : 16'd0;
    end
  end

endmodule

// File: tb/tb_led_demux_meter.sv
// Scoreboard bench for led_demux_meter (WIN_LOG2 = 8): directed windows plus random traffic.
module tb_led_demux_meter;

  localparam int unsigned WinLog2 = 8;
  localparam int WinLen = 1 << WinLog2;
  localparam int SatMax = WinLen - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] ledc = '0;
  logic [2:0]  leda = '0;
  logic        rd_req = 1'b0;
  logic [5:0]  rd_addr = '0;
  logic        rd_ack;
  logic [15:0] rd_data;
  logic        win_done;
  logic        err_anode;
  logic        err_clr = 1'b0;

  led_demux_meter #(.WIN_LOG2(WinLog2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ledc     (ledc),
    .leda     (leda),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_ack   (rd_ack),
    .rd_data  (rd_data),
    .win_done (win_done),
    .err_anode(err_anode),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic mon_en = 1'b0;

  typedef struct {int at; int data;} ack_t;
  ack_t ack_q[$];
  int   wd_q[$];

  // Reference model: per-window on-counts per (led, anode) and the bank visible to reads
  int cnt[11][3];
  int bank_vis[11][3];
  int bank_pend[11][3];
  int pend_at = -1;
  int nsamp = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int anode_of(input int led, input int sel);
`ifdef LED_DEMUX_COLOR_MAP_EN
    int r[11] = '{0, 2, 0, 2, 0, 2, 2, 1, 1, 0, 0};
    int g[11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};
    int b[11] = '{2, 0, 2, 0, 2, 0, 0, 2, 2, 2, 2};
    if (sel == 0) return r[led];
    if (sel == 1) return g[led];
    return b[led];
`else
    return sel + 0 * led;
`endif
  endfunction

  function automatic int exp_read(input int addr);
    if (addr >= 33) return 0;
    return bank_vis[addr / 3][anode_of(addr / 3, addr % 3)];
  endfunction

  task automatic clear_counts();
    for (int l = 0; l < 11; l++)
      for (int k = 0; k < 3; k++) cnt[l][k] = 0;
    nsamp = 0;
  endtask

  // One cycle of stimulus; the model predicts every response it causes
  task automatic drive(input logic [10:0] c, input logic [2:0] a, input logic req,
                       input logic [5:0] addr, input logic clr, input logic rst);
    int j;
    int an;
    @(posedge clk);
    #1;
    j = cyc;
    if (pend_at >= 0 && j >= pend_at) begin
      bank_vis = bank_pend;
      pend_at = -1;
    end
    ledc = c; leda = a; rd_req = req; rd_addr = addr; err_clr = clr; rst_n = rst;
    if (!rst) begin
      clear_counts();
      for (int l = 0; l < 11; l++)
        for (int k = 0; k < 3; k++) bank_vis[l][k] = 0;
      pend_at = -1;
    end else begin
      if (req) ack_q.push_back('{j + 1, exp_read(int'(addr))});
      nsamp++;
      an = (a == 3'b001) ? 0 : (a == 3'b010) ? 1 : (a == 3'b100) ? 2 : -1;
      if (an >= 0)
        for (int l = 0; l < 11; l++) if (c[l]) cnt[l][an]++;
      if (nsamp == WinLen) begin
        for (int l = 0; l < 11; l++)
          for (int k = 0; k < 3; k++) bank_pend[l][k] = (cnt[l][k] > SatMax) ? SatMax : cnt[l][k];
        pend_at = j + 2;
        wd_q.push_back(j + 2);
        clear_counts();
      end
    end
  endtask

  task automatic idle(input logic [10:0] c, input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) drive(c, a, 1'b0, 6'd0, 1'b0, 1'b1);
  endtask

  // Monitor: pops expectations whenever the DUT presents an ack or a window pulse
  always @(negedge clk) begin
    if (mon_en) begin
      while (ack_q.size() > 0 && ack_q[0].at < cyc) begin
        chk("missed_ack", 0, 1);
        void'(ack_q.pop_front());
      end
      while (wd_q.size() > 0 && wd_q[0] < cyc) begin
        chk("missed_win_done", 0, 1);
        void'(wd_q.pop_front());
      end
      if (rd_ack) begin
        if (ack_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          ack_t e;
          e = ack_q.pop_front();
          chk("ack_cycle", cyc, e.at);
          chk("rd_data", int'(rd_data), e.data);
        end
      end else begin
        chk("idle_rd_data", int'(rd_data), 0);
      end
      if (win_done) begin
        if (wd_q.size() == 0) chk("unexpected_win_done", 1, 0);
        else chk("win_done_cycle", cyc, wd_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] ra;
    clear_counts();
    for (int l = 0; l < 11; l++)
      for (int k = 0; k < 3; k++) bank_vis[l][k] = 0;

    // Reset state
    for (int i = 0; i < 3; i++) drive('0, '0, 1'b0, 6'd0, 1'b0, 1'b0);
    chk("reset_rd_ack", int'(rd_ack), 0);
    chk("reset_rd_data", int'(rd_data), 0);
    chk("reset_win_done", int'(win_done), 0);
    chk("reset_err", int'(err_anode), 0);
    mon_en = 1'b1;

    // Window 1: saturation, back-to-back reads at the end of the window
    for (int i = 0; i < WinLen; i++)
      drive(11'h7FF, 3'b001, i >= WinLen - 3, 6'd0, 1'b0, 1'b1);
    chk("no_err_after_valid", int'(err_anode), 0);

    // Window 2: rotation; early reads cover the bank-update edge and out-of-range addr
    for (int i = 0; i < WinLen; i++) begin
      logic [2:0] a;
      logic [5:0] ad;
      a = 3'b001 << (i % 3);
      ad = (i == 3) ? 6'd1 : (i == 4) ? 6'd30 : (i == 5) ? 6'd40 : 6'd0;
      drive((a == 3'b010) ? 11'h008 : 11'h000, a, i < 6, ad, 1'b0, 1'b1);
    end

    // Window 3: rotation results, then protocol-error handling
    drive('0, 3'b001, 1'b0, 6'd0, 1'b0, 1'b1);
    drive('0, 3'b001, 1'b1, 6'd10, 1'b0, 1'b1);
    drive('0, 3'b001, 1'b1, 6'd9, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) drive(11'h7FF, 3'b011, 1'b0, 6'd0, 1'b0, 1'b1);
    idle('0, 3'b010, 2);
    chk("err_set", int'(err_anode), 1);
    drive('0, 3'b010, 1'b0, 6'd0, 1'b1, 1'b1);
    idle('0, 3'b010, 1);
    chk("err_cleared", int'(err_anode), 0);
    for (int i = 0; i < 5; i++) drive(11'h7FF, 3'b000, 1'b0, 6'd0, i == 2, 1'b1);
    chk("err_clr_with_error", int'(err_anode), 1);
    idle('0, 3'b100, 2);
    chk("err_still_set", int'(err_anode), 1);
    drive('0, 3'b100, 1'b0, 6'd0, 1'b1, 1'b1);
    idle('0, 3'b100, 1);
    chk("err_cleared_again", int'(err_anode), 0);
    while (nsamp != 0) drive(11'h040, 3'b100, 1'b0, 6'd0, 1'b0, 1'b1);

    // Window 4: constant single-channel drive for the colour-map check
    for (int i = 0; i < WinLen; i++) drive(11'h002, 3'b100, 1'b0, 6'd0, 1'b0, 1'b1);

    // Window 5: read results, then reset mid-window with a request in flight
    drive('0, 3'b001, 1'b0, 6'd0, 1'b0, 1'b1);
    drive('0, 3'b001, 1'b1, 6'd3, 1'b0, 1'b1);
    drive('0, 3'b001, 1'b1, 6'd5, 1'b0, 1'b1);
    drive('0, 3'b001, 1'b1, 6'd63, 1'b0, 1'b1);
    while (nsamp < 99) drive(11'h7FF, 3'b010, 1'b0, 6'd0, 1'b0, 1'b1);
    drive(11'h7FF, 3'b010, 1'b1, 6'd4, 1'b0, 1'b1);
    drive(11'h7FF, 3'b010, 1'b1, 6'd4, 1'b0, 1'b0);
    drive(11'h7FF, 3'b010, 1'b0, 6'd0, 1'b0, 1'b1);
    chk("rst_mid_rd_ack", int'(rd_ack), 0);
    chk("rst_mid_rd_data", int'(rd_data), 0);
    chk("rst_mid_win_done", int'(win_done), 0);
    chk("rst_mid_err", int'(err_anode), 0);
    drive(11'h7FF, 3'b010, 1'b1, 6'd4, 1'b0, 1'b1);

    // Random traffic over several windows
    for (int i = 0; i < 3 * WinLen; i++) begin
      if ($urandom_range(0, 9) < 8) ra = 3'b001 << $urandom_range(0, 2);
      else ra = 3'($urandom_range(0, 7));
      drive(11'($urandom_range(0, 2047)), ra, $urandom_range(0, 2) == 0,
            6'($urandom_range(0, 63)), 1'b0, 1'b1);
    end

    // Drain and confirm every expectation was consumed
    for (int i = 0; i < 6; i++) drive('0, 3'b001, i < 4, 6'(i * 2), 1'b0, 1'b1);
    idle('0, 3'b001, 4);
    chk("ack_queue_empty", ack_q.size(), 0);
    chk("win_done_queue_empty", wd_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
